// File: rtl/z_reg_scoreboard.sv
// z_reg_scoreboard
//   Register-index decoder plus per-register busy scoreboard for in-flight
//   writes. Stalls issue on RAW/WAW hazards and drives a registered one-hot
//   register-file write enable at writeback. Register 0 is hardwired and is
//   never tracked.
//
// Parameters:
//   SEL_W        register index width (default 5)
//   NREG         1<<SEL_W architectural registers (local, not overridable)
//
// Ports:
//   clock        system clock, rising edge
//   reset        asynchronous, active-low reset
//   issue_valid  instruction presented for issue
//   issue_rd     destination register
//   issue_rs1    source register 1
//   issue_rs2    source register 2
//   issue_ready  issue can be accepted this cycle (combinational)
//   wb_valid     writeback retiring this cycle
//   wb_rd        writeback destination register
//   wen_onehot   registered one-hot register-file write enable (1-cycle pulse)
//   busy_vec     registered scoreboard state
//   pending_cnt  registered population count of busy_vec
//   wb_err       sticky: writeback to a register that was not busy
//
// Build option:
//   Z_SCOREBOARD_BYPASS_EN  when defined, a register retiring this cycle is
//                           treated as free by the hazard check, adding a
//                           combinational path wb_valid/wb_rd -> issue_ready.

module z_reg_scoreboard #(
  parameter  int unsigned SEL_W = 5,
  localparam int unsigned NREG  = 1 << SEL_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             issue_valid,
  input  logic [SEL_W-1:0] issue_rd,
  input  logic [SEL_W-1:0] issue_rs1,
  input  logic [SEL_W-1:0] issue_rs2,
  output logic             issue_ready,
  input  logic             wb_valid,
  input  logic [SEL_W-1:0] wb_rd,
  output logic [NREG-1:0]  wen_onehot,
  output logic [NREG-1:0]  busy_vec,
  output logic [SEL_W:0]   pending_cnt,
  output logic             wb_err
);

  // One-hot decode with register 0 masked out.
  function automatic logic [NREG-1:0] dec_nz(input logic [SEL_W-1:0] idx);
    logic [NREG-1:0] d;
    d      = '0;
    d[idx] = 1'b1;
    d[0]   = 1'b0;
    return d;
  endfunction

  logic [NREG-1:0] wb_mask;
  logic [NREG-1:0] set_mask;
  logic [NREG-1:0] busy_chk;
  logic [NREG-1:0] busy_nxt;
  logic [SEL_W:0]  cnt_nxt;
  logic            haz;
  logic            accept;
  logic            err_nxt;

  always_comb begin
    wb_mask = '0;
    if (wb_valid) wb_mask = dec_nz(wb_rd);
  end

`ifdef Z_SCOREBOARD_BYPASS_EN
  // A producer retiring this cycle no longer blocks its consumers.
  always_comb busy_chk = busy_vec & ~wb_mask;
`else
  always_comb busy_chk = busy_vec;
`endif

  always_comb begin
    haz = 1'b0;
    if (issue_rs1 != '0 && busy_chk[issue_rs1]) haz = 1'b1;
    if (issue_rs2 != '0 && busy_chk[issue_rs2]) haz = 1'b1;
    if (issue_rd  != '0 && busy_chk[issue_rd])  haz = 1'b1;
  end

  assign issue_ready = ~haz;
  assign accept      = issue_valid & ~haz;

  always_comb begin
    set_mask = '0;
    if (accept) set_mask = dec_nz(issue_rd);
  end

  // Set is applied after clear so a same-register set/clear leaves it busy.
  always_comb begin
    busy_nxt    = (busy_vec & ~wb_mask) | set_mask;
    busy_nxt[0] = 1'b0;
  end

  always_comb begin
    cnt_nxt = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      cnt_nxt = cnt_nxt + {{SEL_W{1'b0}}, busy_nxt[i]};
    end
  end

  always_comb begin
    err_nxt = wb_err;
    if (wb_valid && wb_rd != '0 && !busy_vec[wb_rd]) err_nxt = 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      busy_vec    <= '0;
      wen_onehot  <= '0;
      pending_cnt <= '0;
      wb_err      <= 1'b0;
    end else begin
      busy_vec    <= busy_nxt;
      wen_onehot  <= wb_mask;
      pending_cnt <= cnt_nxt;
      wb_err      <= err_nxt;
    end
  end

endmodule

// File: tb/tb_z_reg_scoreboard.sv
module tb_z_reg_scoreboard;

  logic        clock;
  logic        reset;
  logic        issue_valid;
  logic [4:0]  issue_rd, issue_rs1, issue_rs2;
  logic        issue_ready;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wen_onehot, busy_vec;
  logic [5:0]  pending_cnt;
  logic        wb_err;

  logic        issue_valid3;
  logic [2:0]  issue_rd3, issue_rs13, issue_rs23;
  logic        issue_ready3;
  logic        wb_valid3;
  logic [2:0]  wb_rd3;
  logic [7:0]  wen_onehot3, busy_vec3;
  logic [3:0]  pending_cnt3;
  logic        wb_err3;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] busy;
    logic [5:0]  cnt;
    logic [31:0] wen;
    logic        err;
  } exp_t;

  exp_t        q[$];
  logic [31:0] m_busy;
  logic        m_err;

  z_reg_scoreboard #(.SEL_W(5)) dut (
    .clock(clock), .reset(reset),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_ready(issue_ready),
    .wb_valid(wb_valid), .wb_rd(wb_rd),
    .wen_onehot(wen_onehot), .busy_vec(busy_vec),
    .pending_cnt(pending_cnt), .wb_err(wb_err)
  );

  z_reg_scoreboard #(.SEL_W(3)) dut3 (
    .clock(clock), .reset(reset),
    .issue_valid(issue_valid3), .issue_rd(issue_rd3),
    .issue_rs1(issue_rs13), .issue_rs2(issue_rs23),
    .issue_ready(issue_ready3),
    .wb_valid(wb_valid3), .wb_rd(wb_rd3),
    .wen_onehot(wen_onehot3), .busy_vec(busy_vec3),
    .pending_cnt(pending_cnt3), .wb_err(wb_err3)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive, check issue_ready against the model, push the expected
  // registered outputs, then pop and compare them after the edge.
  task automatic step(input logic iv, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic wv, input logic [4:0] wrd);
    logic [31:0] cb, nb;
    logic        haz, acc;
    exp_t        e;
    issue_valid = iv; issue_rd = rd; issue_rs1 = rs1; issue_rs2 = rs2;
    wb_valid = wv; wb_rd = wrd;
    #1;
    cb = m_busy;
`ifdef Z_SCOREBOARD_BYPASS_EN
    if (wv) cb[wrd] = 1'b0;
`endif
    haz = (rs1 != 0 && cb[rs1]) || (rs2 != 0 && cb[rs2]) || (rd != 0 && cb[rd]);
    chk("issue_ready", {63'd0, issue_ready}, {63'd0, !haz});
    acc = iv && !haz;
    nb = m_busy;
    if (wv) nb[wrd] = 1'b0;
    if (acc && rd != 0) nb[rd] = 1'b1;
    nb[0] = 1'b0;
    e.wen = (wv && wrd != 0) ? (32'd1 << wrd) : 32'd0;
    if (wv && wrd != 0 && !m_busy[wrd]) m_err = 1'b1;
    m_busy = nb;
    e.busy = nb;
    e.cnt  = 6'($countones(nb));
    e.err  = m_err;
    q.push_back(e);
    @(posedge clock);
    #1;
    e = q.pop_front();
    chk("busy_vec",    {32'd0, busy_vec},    {32'd0, e.busy});
    chk("pending_cnt", {58'd0, pending_cnt}, {58'd0, e.cnt});
    chk("wen_onehot",  {32'd0, wen_onehot},  {32'd0, e.wen});
    chk("wb_err",      {63'd0, wb_err},      {63'd0, e.err});
  endtask

  initial begin
    reset = 1'b0;
    issue_valid = 0; issue_rd = 0; issue_rs1 = 0; issue_rs2 = 0;
    wb_valid = 0; wb_rd = 0;
    issue_valid3 = 0; issue_rd3 = 0; issue_rs13 = 0; issue_rs23 = 0;
    wb_valid3 = 0; wb_rd3 = 0;
    m_busy = '0; m_err = 1'b0;
    #1;
    chk("rst_busy",  {32'd0, busy_vec},    64'd0);
    chk("rst_cnt",   {58'd0, pending_cnt}, 64'd0);
    chk("rst_ready", {63'd0, issue_ready}, 64'd1);
    chk("rst_wen",   {32'd0, wen_onehot},  64'd0);
    chk("rst_err",   {63'd0, wb_err},      64'd0);
    #11 reset = 1'b1;

    // Idle after reset
    step(0, 0, 0, 0, 0, 0);
    chk("idle_ready", {63'd0, issue_ready}, 64'd1);

    // Issue rd=5
    step(1, 5, 0, 0, 0, 0);
    chk("rd5_busy", {32'd0, busy_vec}, 64'h20);
    chk("rd5_cnt",  {58'd0, pending_cnt}, 64'd1);

    // RAW on rs1=5 stalls
    issue_valid = 1; issue_rd = 6; issue_rs1 = 5; issue_rs2 = 0; wb_valid = 0;
    #1 chk("raw_stall", {63'd0, issue_ready}, 64'd0);
    step(1, 6, 5, 0, 0, 0);

    // Writeback of 5 while the consumer waits
`ifndef Z_SCOREBOARD_BYPASS_EN
    issue_valid = 1; issue_rd = 6; issue_rs1 = 5; wb_valid = 1; wb_rd = 5;
    #1 chk("wb_cycle_stall", {63'd0, issue_ready}, 64'd0);
`endif
    step(1, 6, 5, 0, 1, 5);
    chk("wb5_wen", {32'd0, wen_onehot}, 64'h20);
`ifdef Z_SCOREBOARD_BYPASS_EN
    chk("wb5_busy_byp", {32'd0, busy_vec}, 64'h40);
    step(0, 0, 0, 0, 0, 0);
`else
    chk("wb5_busy", {32'd0, busy_vec}, 64'h0);
    chk("wb5_cnt",  {58'd0, pending_cnt}, 64'd0);
    step(1, 6, 5, 0, 0, 0);
`endif
    chk("consumer_busy", {32'd0, busy_vec}, 64'h40);
    chk("wen_pulse_end", {32'd0, wen_onehot}, 64'h0);

    // Register 0 on both sides
    step(1, 0, 0, 0, 1, 0);
    chk("r0_busy", {32'd0, busy_vec}, 64'h40);
    chk("r0_wen",  {32'd0, wen_onehot}, 64'h0);
    chk("r0_err",  {63'd0, wb_err}, 64'd0);

    // Writeback to a non-busy register
    step(0, 0, 0, 0, 1, 9);
    chk("err_set", {63'd0, wb_err}, 64'd1);
    chk("err_wen", {32'd0, wen_onehot}, 64'h200);
    step(0, 0, 0, 0, 0, 0);
    chk("err_held", {63'd0, wb_err}, 64'd1);
    chk("err_wen_end", {32'd0, wen_onehot}, 64'h0);
    step(0, 0, 0, 0, 1, 6);

    // Reset mid-operation is immediate
    step(1, 31, 0, 0, 0, 0);
    step(1, 3, 0, 0, 0, 0);
    chk("pre_rst_busy", {32'd0, busy_vec}, 64'h80000008);
    issue_valid = 0; wb_valid = 0;
    reset = 1'b0;
    #1;
    chk("async_busy",  {32'd0, busy_vec},    64'd0);
    chk("async_cnt",   {58'd0, pending_cnt}, 64'd0);
    chk("async_err",   {63'd0, wb_err},      64'd0);
    chk("async_ready", {63'd0, issue_ready}, 64'd1);
    m_busy = '0; m_err = 1'b0; q.delete();
    #2 reset = 1'b1;

    // Narrow instance
    issue_valid3 = 1; issue_rd3 = 7;
    @(posedge clock); #1;
    issue_valid3 = 0;
    chk("w3_busy", {56'd0, busy_vec3},    64'h80);
    chk("w3_cnt",  {60'd0, pending_cnt3}, 64'd1);

    // Random traffic on a small register window
    for (int i = 0; i < 60; i++) begin
      step(1'($urandom_range(1, 0)), 5'($urandom_range(7, 0)),
           5'($urandom_range(7, 0)), 5'($urandom_range(7, 0)),
           1'($urandom_range(1, 0)), 5'($urandom_range(7, 0)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
